// File: rtl/shift_deserializer_if.sv
// rtl/shift_deserializer_if.sv - serial input and word output signal bundle for shift_deserializer
interface shift_deserializer_if #(
  parameter int WIDTH = 100
);
  logic             data_i;
  logic             valid_i;
  logic             sync_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             overrun_o;
  logic             clear_i;
  logic             parity_err_o;

  // Drives the serial link and consumes words.
  modport master (
    output data_i, valid_i, sync_i, ready_i, clear_i,
    input  data_o, valid_o, busy_o, overrun_o, parity_err_o
  );

  // The deserializer itself.
  modport slave (
    input  data_i, valid_i, sync_i, ready_i, clear_i,
    output data_o, valid_o, busy_o, overrun_o, parity_err_o
  );
endinterface

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - MSB-first serial-to-parallel converter, optional parity via SHIFT_DESER_PARITY_EN
module shift_deserializer #(
  parameter int WIDTH     = 100,
  parameter int LOG2WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_deserializer_if.slave   bus
);

`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  localparam logic [LOG2WIDTH-1:0] LAST_CNT = LOG2WIDTH'(WIDTH - 1);
  localparam logic [LOG2WIDTH-1:0] ONE_CNT  = LOG2WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [LOG2WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 perr_q, perr_d;
  logic                 complete;
  logic [WIDTH-1:0]     word;
  logic                 word_perr;
  logic                 ovr_set;

  // Next-state for the framing FSM, shift register and output stage.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    perr_d    = perr_q;
    complete  = 1'b0;
    word      = shreg_q;
    word_perr = 1'b0;
    ovr_set   = 1'b0;

    if (bus.valid_i) begin
      case (state_q)
        IDLE: begin
          // Any qualified bit starts a word; it becomes the MSB.
          shreg_d = {{(WIDTH-1){1'b0}}, bus.data_i};
          cnt_d   = ONE_CNT;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (bus.sync_i) begin
            // Resynchronise: drop the partial word silently.
            shreg_d = {{(WIDTH-1){1'b0}}, bus.data_i};
            cnt_d   = ONE_CNT;
          end else begin
            shreg_d = WIDTH'({shreg_q, bus.data_i});
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
`ifdef SHIFT_DESER_PARITY_EN
              state_d = PAR;
`else
              state_d  = IDLE;
              complete = 1'b1;
              word     = WIDTH'({shreg_q, bus.data_i});
`endif
            end else begin
              cnt_d = cnt_q + ONE_CNT;
            end
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PAR: begin
          if (bus.sync_i) begin
            shreg_d = {{(WIDTH-1){1'b0}}, bus.data_i};
            cnt_d   = ONE_CNT;
            state_d = SHIFT;
          end else begin
            // Even parity: data bits plus parity bit must XOR to 0.
            state_d   = IDLE;
            complete  = 1'b1;
            word      = shreg_q;
            word_perr = (^shreg_q) ^ bus.data_i;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    // Output stage: handshake first, then a completing word may refill it.
    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || bus.ready_i) begin
        data_d  = word;
        valid_d = 1'b1;
        perr_d  = word_perr;
      end else begin
        ovr_set = 1'b1;
      end
    end

    // A fresh overrun beats a simultaneous clear.
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (bus.clear_i) begin
      ovr_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.overrun_o = ovr_q;
`ifdef SHIFT_DESER_PARITY_EN
  assign bus.busy_o       = (cnt_q != '0) || (state_q == PAR);
  assign bus.parity_err_o = perr_q;
`else
  assign bus.busy_o       = (cnt_q != '0);
  assign bus.parity_err_o = 1'b0;
`endif

endmodule
